// File: rtl/mdu_wb_merge.sv
// mdu_wb_merge: writeback merge stage behind the mul/div unit.
// Owns the single register-file write port. The in-order pipeline writeback
// always wins the port; an MDU result that cannot be written in its finish
// cycle is parked in a small in-order queue and drained on free cycles.
// Queued destinations drive pend_hit so decode stalls on them, and q_full
// stops the stall unit from issuing another MDU op while the queue is full.
//
// Handshake: there is no back-pressure on either input. wb_valid and
// mdu_finish are single-cycle requests that are always accepted in the cycle
// they are seen; the stall unit throttles the producers with pend_hit and
// q_full instead.
module mdu_wb_merge #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int RW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  input  logic [RW-1:0]            wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     mdu_finish,
  input  logic [RW-1:0]            mdu_now_rd,
  input  logic [XLEN-1:0]          mdu_result,
  input  logic [RW-1:0]            rs1_index,
  input  logic [RW-1:0]            rs2_index,
  output logic                     rf_we,
  output logic [RW-1:0]            rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     pend_hit,
  output logic                     q_full,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Queue storage. r_vld marks entries that still have to be written; an
  // entry can be occupied but invalid after a younger pipeline write killed it.
  logic [RW-1:0]   r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic            r_vld  [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_wb_go;
  logic            w_q_empty;
  logic            w_q_at_full;
  logic            w_head_vld;
  logic            w_head_write;
  logic            w_pop;
  logic            w_mdu_keep;
  logic            w_direct;
  logic            w_enq_req;
  logic            w_enq;
  logic            w_ovf;
  logic            w_we;
  logic [RW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic            w_pend;

  // Request decode: rd=0 writes are architecturally discarded from both sources.
  assign w_wb_go     = wb_valid && (wb_rd != '0);
  assign w_q_empty   = (r_count == '0);
  assign w_q_at_full = (r_count == FULL_CNT);
  assign w_head_vld  = !w_q_empty && r_vld[r_head];

  // Head drains through the port only when the pipeline is not using it.
  assign w_head_write = w_head_vld && !w_wb_go;

  // A killed head never needs the port, so it retires in any cycle.
  assign w_pop = !w_q_empty && (!r_vld[r_head] || !w_wb_go);

  // An MDU result to the same rd as a simultaneous pipeline write is stale.
  assign w_mdu_keep = mdu_finish && (mdu_now_rd != '0) &&
                      !(w_wb_go && (mdu_now_rd == wb_rd));

  // Direct write only with an empty queue so MDU results stay in order.
  assign w_direct  = w_mdu_keep && !w_wb_go && w_q_empty;
  assign w_enq_req = w_mdu_keep && !w_direct;
  assign w_enq     = w_enq_req && (!w_q_at_full || w_pop);
  assign w_ovf     = w_enq_req && w_q_at_full && !w_pop;

  // Write-port mux: pipeline, then queue head, then direct MDU result.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!rst_n) begin
      w_we = 1'b0;
    end else if (w_wb_go) begin
      w_we    = 1'b1;
      w_waddr = wb_rd;
      w_wdata = wb_data;
    end else if (w_head_write) begin
      w_we    = 1'b1;
      w_waddr = r_rd[r_head];
      w_wdata = r_data[r_head];
    end else if (w_direct) begin
      w_we    = 1'b1;
      w_waddr = mdu_now_rd;
      w_wdata = mdu_result;
    end
  end

  // Source hazard against every still-valid queued destination, including a
  // head that is draining this very cycle (no bypass from the write port).
  always_comb begin
    w_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] &&
          (((r_rd[i] == rs1_index) && (rs1_index != '0)) ||
           ((r_rd[i] == rs2_index) && (rs2_index != '0)))) begin
        w_pend = 1'b1;
      end
    end
  end

  // Queue control: kill, pop, enqueue, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
      end
    end else begin
      // Younger pipeline write supersedes any queued result to the same rd.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wb_go && (r_rd[i] == wb_rd)) begin
          r_vld[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + AW'(1);
      end
      // Enqueue last so a full-queue pop+push into the same slot keeps it valid.
      if (w_enq) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + AW'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: r_vld qualifies every read.
  always_ff @(posedge clk) begin
    if (rst_n && w_enq) begin
      r_rd[r_tail]   <= mdu_now_rd;
      r_data[r_tail] <= mdu_result;
    end
  end

  assign rf_we    = w_we;
  assign rf_waddr = w_waddr;
  assign rf_wdata = w_wdata;
  assign pend_hit = rst_n && w_pend;
  assign q_full   = rst_n && w_q_at_full;
  assign q_count  = r_count;
  assign ovf_err  = r_ovf;

endmodule

// File: tb/tb_mdu_wb_merge.sv
// tb_mdu_wb_merge: directed scenarios followed by randomized traffic, every
// cycle compared against a queue-based reference model of the merge rules.
module tb_mdu_wb_merge;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int RW    = 5;

  logic            clk;
  logic            rst_n;
  logic            wb_valid;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            mdu_finish;
  logic [RW-1:0]   mdu_now_rd;
  logic [XLEN-1:0] mdu_result;
  logic [RW-1:0]   rs1_index;
  logic [RW-1:0]   rs2_index;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            pend_hit;
  logic            q_full;
  logic [$clog2(DEPTH):0] q_count;
  logic            ovf_err;

  int checks;
  int failures;

  mdu_wb_merge #(.DEPTH(DEPTH), .XLEN(XLEN), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mdu_finish (mdu_finish),
    .mdu_now_rd (mdu_now_rd),
    .mdu_result (mdu_result),
    .rs1_index  (rs1_index),
    .rs2_index  (rs2_index),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pend_hit   (pend_hit),
    .q_full     (q_full),
    .q_count    (q_count),
    .ovf_err    (ovf_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outstanding MDU results, oldest first.
  typedef struct {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] d;
    logic            v;
  } ent_t;

  ent_t m_q[$];
  logic m_ovf;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver + scoreboard for one clock: apply inputs, check outputs mid-cycle,
  // then advance the model at the edge the DUT samples.
  task automatic step(input logic rst, input logic wv, input logic [RW-1:0] wrd,
                      input logic [XLEN-1:0] wd, input logic mf,
                      input logic [RW-1:0] mrd, input logic [XLEN-1:0] mres,
                      input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    logic            wb_go;
    logic            e_we;
    logic [RW-1:0]   e_addr;
    logic [XLEN-1:0] e_data;
    logic            e_pend;
    logic            popped;
    logic            keep;
    logic            direct;
    int              old_size;

    rst_n = rst; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    mdu_finish = mf; mdu_now_rd = mrd; mdu_result = mres;
    rs1_index = r1; rs2_index = r2;

    wb_go  = wv && (wrd != 0);
    e_we   = 1'b0;
    e_addr = '0;
    e_data = '0;
    if (wb_go) begin
      e_we = 1'b1; e_addr = wrd; e_data = wd;
    end else if (m_q.size() > 0 && m_q[0].v) begin
      e_we = 1'b1; e_addr = m_q[0].rd; e_data = m_q[0].d;
    end else if (mf && mrd != 0 && m_q.size() == 0) begin
      e_we = 1'b1; e_addr = mrd; e_data = mres;
    end
    e_pend = 1'b0;
    foreach (m_q[i]) begin
      if (m_q[i].v && ((m_q[i].rd == r1 && r1 != 0) || (m_q[i].rd == r2 && r2 != 0)))
        e_pend = 1'b1;
    end

    @(negedge clk);
    if (rst) begin
      chk("rf_we", rf_we, e_we);
      chk("rf_waddr", rf_waddr, e_addr);
      chk("rf_wdata", rf_wdata, e_data);
      chk("pend_hit", pend_hit, e_pend);
      chk("q_full", q_full, m_q.size() == DEPTH);
    end else begin
      chk("rst_rf_we", rf_we, 0);
      chk("rst_pend_hit", pend_hit, 0);
      chk("rst_q_full", q_full, 0);
    end
    chk("q_count", q_count, m_q.size());
    chk("ovf_err", ovf_err, m_ovf);

    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      old_size = m_q.size();
      popped = (old_size > 0) && (!m_q[0].v || !wb_go);
      if (wb_go) begin
        foreach (m_q[i]) if (m_q[i].rd == wrd) m_q[i].v = 1'b0;
      end
      if (popped) void'(m_q.pop_front());
      keep   = mf && mrd != 0 && !(wb_go && mrd == wrd);
      direct = keep && !wb_go && old_size == 0;
      if (keep && !direct) begin
        if (m_q.size() < DEPTH) m_q.push_back('{rd: mrd, d: mres, v: 1'b1});
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_ovf    = 1'b0;
    rst_n = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    mdu_finish = 0; mdu_now_rd = 0; mdu_result = 0;
    rs1_index = 0; rs2_index = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Direct write with a free port and empty queue
    step(1, 0, 0, 0, 1, 5, 32'h1234, 0, 0);
    chk("direct_q_count", q_count, 0);

    // Conflict then drain
    step(1, 1, 3, 32'hB, 1, 7, 32'hA, 0, 0);
    chk("conflict_q_count", q_count, 1);
    step(1, 0, 0, 0, 0, 0, 0, 7, 0);
    idle();

    // Kill: queued rd9 superseded by a pipeline write to rd9
    step(1, 1, 3, 32'hB, 1, 9, 32'hA, 0, 0);
    step(1, 1, 9, 32'h55, 0, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0, 9, 0);
    idle();

    // Ordering and overflow
    step(1, 1, 10, 32'h100, 1, 1, 32'h11, 0, 0);
    step(1, 1, 10, 32'h101, 1, 2, 32'h22, 1, 2);
    step(1, 1, 10, 32'h102, 1, 4, 32'h44, 4, 0);
    step(1, 1, 10, 32'h103, 0, 0, 0, 0, 0);
    chk("ovf_sticky", ovf_err, 1);
    idle();
    idle();
    idle();

    // rd=0 never written nor queued
    step(1, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
    step(1, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);

    // Reset mid-drain
    step(1, 1, 3, 32'h1, 1, 12, 32'hC, 0, 0);
    step(1, 1, 3, 32'h2, 1, 13, 32'hD, 12, 13);
    step(0, 0, 0, 0, 0, 0, 0, 12, 13);
    step(1, 0, 0, 0, 0, 0, 0, 12, 13);
    chk("post_reset_count", q_count, 0);
    idle();

    // Randomized traffic on a narrow rd range to force collisions
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 1) == 1), RW'($urandom_range(0, 6)), $urandom,
           ($urandom_range(0, 2) != 0), RW'($urandom_range(0, 6)), $urandom,
           RW'($urandom_range(0, 6)), RW'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_wb_merge.md
Name: mdu_wb_merge

Overview:
- Writeback merge stage directly downstream of the mul/div unit; owns the single register-file write port.
- Merges the in-order pipeline writeback with the MDU's one-cycle finish pulse. Pipeline writeback always has priority.
- MDU results that lose arbitration are queued in a small FIFO and drained on free cycles.
- Drives hazard and stall signals to the stall unit for queued (not yet written) destinations.

Parameters:
- DEPTH, 2, MDU result queue entries (power of 2, ≥2)
- XLEN, 32, data width
- RW, 5, register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wb_valid  in  1  pipeline writeback request this cycle
- wb_rd  in  RW  pipeline destination index
- wb_data  in  XLEN  pipeline write data
- mdu_finish  in  1  MDU result valid (single-cycle pulse)
- mdu_now_rd  in  RW  MDU destination index
- mdu_result  in  XLEN  MDU result
- rs1_index  in  RW  decode source 1 index
- rs2_index  in  RW  decode source 2 index
- rf_we  out  1  register-file write enable
- rf_waddr  out  RW  register-file write index
- rf_wdata  out  XLEN  register-file write data
- pend_hit  out  1  decode source (nonzero) matches a valid queued rd → stall decode
- q_full  out  1  queue full → stall unit must not start a new MDU op
- q_count  out  log2(DEPTH)+1  valid-or-invalidated occupancy
- ovf_err  out  1  sticky: result lost to overflow

Behaviour:
- Clocking: all state updates on posedge clk. When rst_n is low at an edge: queue emptied, all entry valids cleared, pointers and count zeroed, ovf_err cleared.
- Output gating: rf_we, pend_hit and q_full are also gated by rst_n, so they read 0 while reset is asserted. Reset mid-drain discards queued results.
- Write-port outputs are combinational, so write latency is 0 cycles when the port is free.
- Priority per cycle: wb_valid && wb_rd≠0 → port to the pipeline. Else a valid queue head → port to the head (then pop). Else mdu_finish with an empty queue → direct write. Else no write. With no write, rf_we=0 and addr/data are 0.
- rd=0 from either source: never written, never enqueued.
- Enqueue: mdu_finish && mdu_now_rd≠0 is enqueued whenever it cannot be written directly. This covers the port being taken and the queue being non-empty (preserves MDU order).
- Same-cycle pop and enqueue are allowed; count is unchanged.
- Kill (WAW): a pipeline write is younger than any outstanding MDU result.
  - Every queued entry with rd==wb_rd (wb_valid, wb_rd≠0) has its valid cleared that cycle.
  - A simultaneous mdu_finish with mdu_now_rd==wb_rd is dropped, not enqueued.
- Invalidated head: popped without using the port. At most one pop per cycle. If the invalid head pops in a cycle the port is free, the next valid entry drains the following cycle.
- Overflow: enqueue required while count==DEPTH with no pop that cycle → result discarded, ovf_err set (sticky until reset).
- q_full = (count==DEPTH).
- pend_hit: OR over valid entries of (rd==rs1_index && rs1_index≠0) or (rd==rs2_index && rs2_index≠0). Entries being popped this cycle still count as hits (no bypass).
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH.

Test Plan:
- Direct write: reset, then mdu_finish=1, rd=5, result=0x1234, wb_valid=0 → same cycle rf_we=1, waddr=5, wdata=0x1234; q_count stays 0.
- Conflict and drain: mdu_finish rd=7 data=0xA with wb_valid rd=3 data=0xB.
  - Cycle 0 writes rd3 = 0xB; q_count=1; pend_hit=1 for rs1=7.
  - Cycle 1 (wb_valid=0) writes rd7 = 0xA; q_count=0.
- Kill: queue holds rd=9, then wb_valid rd=9 data=0x55 → rd9 = 0x55 written. The next free cycle pops with rf_we=0, and 0xA is never written to rd9.
- Ordering and overflow (DEPTH=2): wb_valid held high for 4 cycles, mdu_finish rd=1,2,4 on cycles 0,1,2 → q_full=1 after cycle 1. Result rd4 is dropped, ovf_err=1. After release, rd1 then rd2 are written in successive cycles.
- rd=0 and reset: mdu_finish rd=0 → no write, no enqueue. With 2 entries queued, rst_n=0 for one edge → q_count=0, pend_hit=0, and no subsequent writes.
